fractal_view_ctrl: RTL and testbench
====================================

FRACTAL_VIEW_CTRL -- requirements
Module: fractal_view_ctrl

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- H_PIX, 640: visible pixels per line.
- V_PIX, 480: visible lines per frame.
- PAN_SHIFT, 5: pan distance is 2^PAN_SHIFT pixels.
- STEP_MAX, 16'h0100: largest permitted step on either axis.
- HOME_SX, 16'hE000: startX value for the home view.
- HOME_SY, 16'hE000: startY value for the home view.
- HOME_DX, 16'h0019: stepX value for the home view.
- HOME_DY, 16'h0022: stepY value for the home view.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- Clk_100M, in, 1: the single clock; all logic is on its rising edge.
- reset, in, 1: synchronous, active-high.
- VS, in, 1: vertical sync, active-low, asynchronous to the block.
- cmd_valid, in, 1: a command is offered.
- cmd_op, in, 3: command opcode.
- cmd_ready, out, 1: the block can accept a command.
- startX, out, 16: signed Q2.13 real coordinate of pixel column 0.
- startY, out, 16: signed Q2.13 imaginary coordinate of line 0.
- stepX, out, 16: unsigned Q2.13 real increment per pixel.
- stepY, out, 16: unsigned Q2.13 imaginary increment per line.
- view_update, out, 1: one-cycle pulse when a new view is committed.

REQ-003 cmd_op encoding SHALL be: 0 NOP, 1 PAN_L, 2 PAN_R, 3 PAN_U, 4 PAN_D, 5 ZOOM_IN, 6 ZOOM_OUT, 7 HOME.

Function
REQ-010 A command SHALL be accepted on the cycle where cmd_valid and cmd_ready are both high; the block latches cmd_op into a one-deep pending register.
REQ-011 cmd_ready SHALL be high only in state IDLE.
REQ-012 The FSM SHALL have the states IDLE, PEND, CALC_X, CALC_Y and COMMIT, with these transitions:
- IDLE to PEND on accept.
- PEND to CALC_X on a detected VS falling edge.
- CALC_X to CALC_Y to COMMIT unconditionally.
- COMMIT to IDLE.
REQ-013 VS SHALL pass through a 2-flop synchronizer. A falling edge SHALL be detected when the sync output is low and was high on the previous cycle.
REQ-014 A falling edge that occurs outside PEND SHALL be ignored.
REQ-015 CALC_X/CALC_Y SHALL compute candidate values into shadow registers. The outputs SHALL update only in COMMIT, all four together, with view_update=1 in that same cycle.
REQ-016 From the edge-detect cycle, the outputs SHALL change 3 clock edges later. The outputs SHALL otherwise hold for the whole frame.
REQ-017 PAN_L/PAN_R SHALL set startX to startX minus/plus (stepX shifted left by PAN_SHIFT). PAN_U/PAN_D SHALL do the same on startY using stepY.
REQ-018 ZOOM_IN SHALL apply the following, with the centre preserved:
- ns = step>>1 on each axis.
- startX += (stepX-nsX)*(H_PIX/2).
- startY += (stepY-nsY)*(V_PIX/2).
- If either nsX or nsY would be 0, neither axis changes.
REQ-019 ZOOM_OUT SHALL apply the following:
- ns = step<<1 on each axis.
- startX -= stepX*(H_PIX/2).
- startY -= stepY*(V_PIX/2).
- If either ns would exceed STEP_MAX, neither axis changes.
REQ-020 HOME SHALL load HOME_SX/SY/DX/DY. NOP SHALL commit unchanged values and still pulse view_update.
REQ-021 All start arithmetic SHALL use at least 26-bit signed intermediates. The result SHALL saturate to 16'h8000..16'h7FFF. Constant multiplies SHALL use shift-and-add, with no multiplier primitives.
REQ-022 A blocked zoom (REQ-018/019) SHALL still consume the command and pulse view_update.

Reset
REQ-030 While reset=1, the block SHALL be in the following state:
- FSM in IDLE, cmd_ready=1 on the first cycle after reset deasserts.
- Pending register cleared; any in-flight command is discarded.
- startX=HOME_SX, startY=HOME_SY, stepX=HOME_DX, stepY=HOME_DY.
- view_update=0; synchronizer flops set to 1 (VS inactive).
REQ-031 A reset asserted in any state, including mid-CALC, SHALL take effect at the next clock edge with no partial commit.

Structure
REQ-040 The opcode constants, the Q2.13 format constants (FRAC_BITS=13) and the home-view defaults SHALL live in the shared package fractal_view_pkg.
REQ-041 The synchronizer and falling-edge detector SHALL be the sub-module sync_fall_det (ports clk, reset, async_in, fall_pulse). The arithmetic and FSM SHALL stay in fractal_view_ctrl.
REQ-042 The four outputs SHALL drive the fractal core's startX/startY/stepX/stepY inputs directly.

Verification
REQ-050 Reset: pulse reset, then idle.
- Outputs = E000/E000/0019/0022, cmd_ready=1, view_update=0.
REQ-051 PAN_R from home, then a VS falling edge.
- startX=16'hE320, other outputs unchanged.
- Exactly one view_update pulse, 3 edges after detection.
- No change before the VS edge.
REQ-052 ZOOM_IN from home.
- stepX=000C, stepY=0011, startX=F040, startY=EFF0.
REQ-053 ZOOM_OUT from home.
- stepX=0032, stepY=0044, startX=C0C0, startY=C020.
- Ten further ZOOM_OUTs: stepX never exceeds 0100.
- Both axes freeze on the same command.
REQ-054 40 PAN_L from home.
- startX saturates at 16'h8000 and holds without wrap.
REQ-055 Offer a second cmd_valid while in PEND.
- cmd_ready=0 and the second command is not accepted.
- Assert reset during CALC_Y: outputs return to home with no view_update.

Source files
------------

// File: rtl/fractal_view_pkg.sv
// rtl/fractal_view_pkg.sv - shared opcodes, Q2.13 constants, home view and helpers for the view controller
package fractal_view_pkg;

    localparam int FRAC_BITS = 13;
    localparam int CALC_W    = 26;

    localparam logic [15:0] HOME_SX_DEF = 16'hE000;
    localparam logic [15:0] HOME_SY_DEF = 16'hE000;
    localparam logic [15:0] HOME_DX_DEF = 16'h0019;
    localparam logic [15:0] HOME_DY_DEF = 16'h0022;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_PAN_L    = 3'd1,
        OP_PAN_R    = 3'd2,
        OP_PAN_U    = 3'd3,
        OP_PAN_D    = 3'd4,
        OP_ZOOM_IN  = 3'd5,
        OP_ZOOM_OUT = 3'd6,
        OP_HOME     = 3'd7
    } cmd_op_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PEND   = 3'd1,
        CALC_X = 3'd2,
        CALC_Y = 3'd3,
        COMMIT = 3'd4
    } state_t;

    // One axis of the view: signed start coordinate and unsigned step.
    typedef struct packed {
        logic [15:0] start;
        logic [15:0] step;
    } axis_t;

    // Clamp a wide signed start value into the 16-bit Q2.13 range.
    function automatic logic [15:0] sat16(input logic signed [CALC_W-1:0] v);
        if (v > 26'sd32767) begin
            return 16'h7FFF;
        end else if (v < -26'sd32768) begin
            return 16'h8000;
        end else begin
            return v[15:0];
        end
    endfunction

    // Multiply by an elaboration-time constant as a sum of shifted copies,
    // so only adders are built.
    function automatic logic signed [CALC_W-1:0] mul_const(input logic signed [CALC_W-1:0] a,
                                                           input int k);
        logic signed [CALC_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            if (k[i]) begin
                acc = acc + (a <<< i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/sync_fall_det.sv
// rtl/sync_fall_det.sv - two-flop synchronizer with falling-edge pulse
// clk        : clock
// reset      : synchronous active-high reset, flops preset to 1 (input idle high)
// async_in   : asynchronous active-low input
// fall_pulse : one-cycle pulse when the synchronized input goes 1 -> 0
module sync_fall_det (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic fall_pulse
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1    <= 1'b1;
            sync_2    <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync_1    <= async_in;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    assign fall_pulse = sync_prev & ~sync_2;

endmodule

// File: rtl/fractal_view_ctrl.sv
// rtl/fractal_view_ctrl.sv - pan/zoom view controller committing new fractal coordinates on VS
// Clk_100M    : clock, rising edge
// reset       : synchronous active-high reset
// VS          : asynchronous active-low vertical sync
// cmd_valid   : command offered; cmd_op : opcode; cmd_ready : accepting (IDLE only)
// startX/Y    : signed Q2.13 coordinate of column 0 / line 0
// stepX/Y     : unsigned Q2.13 increment per pixel / line
// view_update : one-cycle pulse in the cycle the new view appears
module fractal_view_ctrl
    import fractal_view_pkg::*;
#(
    parameter int          H_PIX     = 640,
    parameter int          V_PIX     = 480,
    parameter int          PAN_SHIFT = 5,
    parameter logic [15:0] STEP_MAX  = 16'h0100,
    parameter logic [15:0] HOME_SX   = HOME_SX_DEF,
    parameter logic [15:0] HOME_SY   = HOME_SY_DEF,
    parameter logic [15:0] HOME_DX   = HOME_DX_DEF,
    parameter logic [15:0] HOME_DY   = HOME_DY_DEF
) (
    input  logic        Clk_100M,
    input  logic        reset,
    input  logic        VS,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_op,
    output logic        cmd_ready,
    output logic [15:0] startX,
    output logic [15:0] startY,
    output logic [15:0] stepX,
    output logic [15:0] stepY,
    output logic        view_update
);

    state_t  state_q;
    state_t  state_n;
    cmd_op_t pend_op;
    axis_t   shadow_x;
    axis_t   x_next;
    axis_t   y_next;
    logic    vs_fall;
    logic    accept;
    logic    zin_block;
    logic    zout_block;

    sync_fall_det u_vs_det (
        .clk        (Clk_100M),
        .reset      (reset),
        .async_in   (VS),
        .fall_pulse (vs_fall)
    );

    assign cmd_ready   = (state_q == IDLE);
    assign accept      = cmd_valid & cmd_ready;
    assign view_update = (state_q == COMMIT);

    // A zoom moves both axes or neither, so the limits are judged jointly.
    assign zin_block  = ((stepX >> 1) == 16'd0) || ((stepY >> 1) == 16'd0);
    assign zout_block = ({stepX, 1'b0} > {1'b0, STEP_MAX}) || ({stepY, 1'b0} > {1'b0, STEP_MAX});

    function automatic axis_t axis_next(input cmd_op_t     op,
                                        input logic [15:0] start,
                                        input logic [15:0] step,
                                        input int          half,
                                        input cmd_op_t     op_dec,
                                        input cmd_op_t     op_inc,
                                        input logic [15:0] home_start,
                                        input logic [15:0] home_step,
                                        input logic        blk_in,
                                        input logic        blk_out);
        logic signed [CALC_W-1:0] s;
        logic signed [CALC_W-1:0] d;
        logic signed [CALC_W-1:0] ns;
        axis_t res;
        s         = CALC_W'(signed'(start));
        d         = signed'(CALC_W'(step));
        ns        = signed'(CALC_W'(step >> 1));
        res.start = start;
        res.step  = step;
        case (op)
            OP_HOME: begin
                res.start = home_start;
                res.step  = home_step;
            end
            OP_ZOOM_IN: begin
                // Shift start by the shrink of half a screen so the centre stays put.
                if (!blk_in) begin
                    res.start = sat16(s + mul_const(d - ns, half));
                    res.step  = step >> 1;
                end
            end
            OP_ZOOM_OUT: begin
                if (!blk_out) begin
                    res.start = sat16(s - mul_const(d, half));
                    res.step  = step << 1;
                end
            end
            default: begin
                if (op == op_dec) begin
                    res.start = sat16(s - (d <<< PAN_SHIFT));
                end else if (op == op_inc) begin
                    res.start = sat16(s + (d <<< PAN_SHIFT));
                end
            end
        endcase
        return res;
    endfunction

    assign x_next = axis_next(pend_op, startX, stepX, H_PIX / 2, OP_PAN_L, OP_PAN_R,
                              HOME_SX, HOME_DX, zin_block, zout_block);
    assign y_next = axis_next(pend_op, startY, stepY, V_PIX / 2, OP_PAN_U, OP_PAN_D,
                              HOME_SY, HOME_DY, zin_block, zout_block);

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (accept)  state_n = PEND;
            PEND:    if (vs_fall) state_n = CALC_X;
            CALC_X:  state_n = CALC_Y;
            CALC_Y:  state_n = COMMIT;
            COMMIT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // X is staged in CALC_X; Y is formed in CALC_Y and all four outputs load
    // together on the edge into COMMIT, so the new view is visible in the
    // same cycle as view_update.
    always_ff @(posedge Clk_100M) begin
        if (reset) begin
            state_q  <= IDLE;
            pend_op  <= OP_NOP;
            shadow_x <= '{start: HOME_SX, step: HOME_DX};
            startX   <= HOME_SX;
            startY   <= HOME_SY;
            stepX    <= HOME_DX;
            stepY    <= HOME_DY;
        end else begin
            state_q <= state_n;
            if (accept) begin
                pend_op <= cmd_op_t'(cmd_op);
            end
            if (state_q == CALC_X) begin
                shadow_x <= x_next;
            end
            if (state_q == CALC_Y) begin
                startX <= shadow_x.start;
                stepX  <= shadow_x.step;
                startY <= y_next.start;
                stepY  <= y_next.step;
            end
        end
    end

endmodule

// File: tb/tb_fractal_view_ctrl.sv
// tb/tb_fractal_view_ctrl.sv - directed self-checking bench for fractal_view_ctrl
module tb_fractal_view_ctrl;

    logic        Clk_100M = 1'b0;
    logic        reset    = 1'b1;
    logic        VS       = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op   = 3'd0;
    logic        cmd_ready;
    logic [15:0] startX;
    logic [15:0] startY;
    logic [15:0] stepX;
    logic [15:0] stepY;
    logic        view_update;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] HOME_VIEW = {16'hE000, 16'hE000, 16'h0019, 16'h0022};

    fractal_view_ctrl dut (
        .Clk_100M    (Clk_100M),
        .reset       (reset),
        .VS          (VS),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_ready   (cmd_ready),
        .startX      (startX),
        .startY      (startY),
        .stepX       (stepX),
        .stepY       (stepY),
        .view_update (view_update)
    );

    always #5 Clk_100M = ~Clk_100M;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks start and end aligned to a falling clock edge.
    task automatic issue(input logic [2:0] op);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge Clk_100M);
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL ready_timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        @(negedge Clk_100M);
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
    endtask

    // Drop VS and watch view_update for 8 cycles; first = sample index of the pulse.
    task automatic vs_edge(output int pulses, output int first);
        VS     = 1'b0;
        pulses = 0;
        first  = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge Clk_100M);
            if (view_update) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        VS = 1'b1;
        repeat (4) @(negedge Clk_100M);
    endtask

    task automatic go_home();
        int p, f;
        issue(3'd7);
        vs_edge(p, f);
        checks++;
        if ({startX, startY, stepX, stepY} !== HOME_VIEW) begin
            failures++;
            $display("FAIL home_cmd: view=%h required %h", {startX, startY, stepX, stepY}, HOME_VIEW);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge Clk_100M);
        reset = 1'b0;
        @(negedge Clk_100M);
        checks++;
        if ({startX, startY, stepX, stepY} !== HOME_VIEW) begin
            failures++;
            $display("FAIL reset_view: view=%h required %h", {startX, startY, stepX, stepY}, HOME_VIEW);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
        end
        checks++;
        if (view_update !== 1'b0) begin
            failures++;
            $display("FAIL reset_update: view_update=%b required 0", view_update);
        end
    endtask

    task automatic test_pan_r();
        int p, f;
        issue(3'd2);
        repeat (3) @(negedge Clk_100M);
        checks++;
        if ({startX, startY, stepX, stepY, view_update} !== {HOME_VIEW, 1'b0}) begin
            failures++;
            $display("FAIL pan_r_early: view=%h upd=%b required %h upd=0",
                     {startX, startY, stepX, stepY}, view_update, HOME_VIEW);
        end
        vs_edge(p, f);
        checks++;
        if (p !== 1 || f !== 5) begin
            failures++;
            $display("FAIL pan_r_pulse: pulses=%0d at=%0d required pulses=1 at=5", p, f);
        end
        checks++;
        if ({startX, startY, stepX, stepY} !== {16'hE320, 16'hE000, 16'h0019, 16'h0022}) begin
            failures++;
            $display("FAIL pan_r_view: view=%h required e320e00000190022", {startX, startY, stepX, stepY});
        end
    endtask

    task automatic test_zoom_in();
        int p, f;
        issue(3'd5);
        vs_edge(p, f);
        checks++;
        if (p !== 1 || f !== 5) begin
            failures++;
            $display("FAIL zoom_in_pulse: pulses=%0d at=%0d required pulses=1 at=5", p, f);
        end
        checks++;
        if ({startX, startY, stepX, stepY} !== {16'hF040, 16'hEFF0, 16'h000C, 16'h0011}) begin
            failures++;
            $display("FAIL zoom_in_view: view=%h required f040eff0000c0011", {startX, startY, stepX, stepY});
        end
    endtask

    task automatic test_zoom_out();
        int p, f;
        issue(3'd6);
        vs_edge(p, f);
        checks++;
        if ({startX, startY, stepX, stepY} !== {16'hC0C0, 16'hC020, 16'h0032, 16'h0044}) begin
            failures++;
            $display("FAIL zoom_out_view: view=%h required c0c0c02000320044", {startX, startY, stepX, stepY});
        end
        for (int k = 1; k <= 10; k++) begin
            issue(3'd6);
            vs_edge(p, f);
            checks++;
            if (p !== 1 || stepX > 16'h0100 || stepY > 16'h0100) begin
                failures++;
                $display("FAIL zoom_out_limit[%0d]: pulses=%0d stepX=%h stepY=%h required pulses=1 steps<=0100",
                         k, p, stepX, stepY);
            end
        end
        // Y hits the limit first (0x88 -> 0x110), so X freezes at 0x64 too.
        checks++;
        if ({startX, startY, stepX, stepY} !== {16'h8240, 16'h8060, 16'h0064, 16'h0088}) begin
            failures++;
            $display("FAIL zoom_out_freeze: view=%h required 8240806000640088", {startX, startY, stepX, stepY});
        end
    endtask

    task automatic test_pan_sat();
        int p, f;
        int exp_x;
        exp_x = -8192;
        for (int k = 1; k <= 40; k++) begin
            issue(3'd1);
            vs_edge(p, f);
            exp_x = exp_x - 800;
            if (exp_x < -32768) exp_x = -32768;
            checks++;
            if (startX !== 16'(exp_x) || p !== 1) begin
                failures++;
                $display("FAIL pan_l_sat[%0d]: startX=%h pulses=%0d required %h pulses=1",
                         k, startX, p, 16'(exp_x));
            end
        end
    endtask

    task automatic test_nop();
        int p, f;
        issue(3'd0);
        vs_edge(p, f);
        checks++;
        if (p !== 1 || {startX, startY, stepX, stepY} !== {16'h8000, 16'hE000, 16'h0019, 16'h0022}) begin
            failures++;
            $display("FAIL nop: pulses=%0d view=%h required pulses=1 view 8000e00000190022",
                     p, {startX, startY, stepX, stepY});
        end
    endtask

    task automatic test_idle_edge();
        int p, f;
        vs_edge(p, f);
        checks++;
        if (p !== 0) begin
            failures++;
            $display("FAIL idle_edge: pulses=%0d required 0", p);
        end
    endtask

    task automatic test_back_to_back();
        int p, f;
        issue(3'd2);
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL pend_ready: cmd_ready=%b required 0", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = 3'd5;
        repeat (2) @(negedge Clk_100M);
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        vs_edge(p, f);
        checks++;
        if (p !== 1 || {startX, startY, stepX, stepY} !== {16'hE320, 16'hE000, 16'h0019, 16'h0022}) begin
            failures++;
            $display("FAIL pend_second: pulses=%0d view=%h required pulses=1 view e320e00000190022",
                     p, {startX, startY, stepX, stepY});
        end
        vs_edge(p, f);
        checks++;
        if (p !== 0) begin
            failures++;
            $display("FAIL pend_dropped: pulses=%0d required 0", p);
        end
    endtask

    task automatic test_reset_calc();
        int p, f;
        issue(3'd4);
        VS = 1'b0;
        repeat (4) @(negedge Clk_100M);
        reset = 1'b1;
        @(negedge Clk_100M);
        checks++;
        if (view_update !== 1'b0 || {startX, startY, stepX, stepY} !== HOME_VIEW) begin
            failures++;
            $display("FAIL reset_calc: upd=%b view=%h required upd=0 view %h",
                     view_update, {startX, startY, stepX, stepY}, HOME_VIEW);
        end
        repeat (2) @(negedge Clk_100M);
        checks++;
        if (view_update !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: view_update=%b required 0", view_update);
        end
        reset = 1'b0;
        VS    = 1'b1;
        @(negedge Clk_100M);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_calc_ready: cmd_ready=%b required 1", cmd_ready);
        end
        repeat (3) @(negedge Clk_100M);
        vs_edge(p, f);
        checks++;
        if (p !== 0 || {startX, startY, stepX, stepY} !== HOME_VIEW) begin
            failures++;
            $display("FAIL reset_discard: pulses=%0d view=%h required 0 and %h",
                     p, {startX, startY, stepX, stepY}, HOME_VIEW);
        end
    endtask

    initial begin
        test_reset();
        test_pan_r();
        go_home();
        test_zoom_in();
        go_home();
        test_zoom_out();
        go_home();
        test_pan_sat();
        test_nop();
        test_idle_edge();
        go_home();
        test_back_to_back();
        test_reset_calc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
